// File: rtl/instr_inv_queue_pkg.sv
// Shared types for the instruction invalidation queue: command format,
// queue state and the CPU configuration knobs that size it.
package instr_inv_queue_pkg;

  typedef enum logic {NORMAL = 1'b0, FLUSH = 1'b1} inv_q_state_t;

  // line_addr sized for the narrowest line (LINE_W = 1); users take the low bits
  typedef struct packed {
    logic        flush_all;
    logic [29:0] line_addr;
  } inv_cmd_t;

  typedef struct packed {
    int INSTR_INV_QUEUE_DEPTH;
    int INSTR_INV_CONSUMERS;
  } cpu_config_t;

  localparam cpu_config_t CPU_CFG_DEFAULT = '{
    INSTR_INV_QUEUE_DEPTH: 4,
    INSTR_INV_CONSUMERS:   2
  };

endpackage

// File: rtl/instr_inv_queue_ring.sv
// Line-address ring buffer: wrap-bit pointers for full/empty, a tail read
// port for duplicate detection and a synchronous clear for overflow.
module inv_ring_buffer #(
  parameter int DEPTH = 4,
  parameter int W     = 28
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic [W-1:0] tail,
  output logic         full,
  output logic         empty,
  output logic         single
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr, rptr;
  logic [AW:0]  occ;

  assign occ    = wptr - rptr;
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign single = (occ == (AW+1)'(1));
  assign head   = mem[rptr[AW-1:0]];
  assign tail   = mem[wptr[AW-1:0] - AW'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // storage needs no reset: readers are gated by empty/state
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/instr_inv_queue.sv
// Instruction-coherency invalidation queue: range filter, tail coalescing,
// multi-consumer broadcast with per-consumer done tracking, flush-all on overflow.
module instr_inv_queue
  import instr_inv_queue_pkg::*;
#(
  parameter int          DEPTH         = CPU_CFG_DEFAULT.INSTR_INV_QUEUE_DEPTH,
  parameter int          NUM_CONSUMERS = CPU_CFG_DEFAULT.INSTR_INV_CONSUMERS,
  parameter int          LINE_W        = 4,
  parameter logic [31:0] ADDR_L        = 32'h8000_0000,
  parameter logic [31:0] ADDR_H        = 32'h8FFF_FFFF,
  localparam int         LINE_ADDR_W   = 30 - $clog2(LINE_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     inv_valid,
  input  logic [31:0]              inv_addr,
  output logic [NUM_CONSUMERS-1:0] out_valid,
  output logic                     out_flush_all,
  output logic [LINE_ADDR_W-1:0]   out_line_addr,
  input  logic [NUM_CONSUMERS-1:0] out_ack,
  output logic                     busy,
  output logic [7:0]               overflow_cnt
);
  inv_q_state_t             state;
  logic [NUM_CONSUMERS-1:0] done, acked;
  logic [LINE_ADDR_W-1:0]   line, q_head, q_tail;
  logic q_full, q_empty, q_single;
  logic accept, dup, push_req, overflow, push, pop, cmd_valid, retire;

  assign line     = inv_addr[31 -: LINE_ADDR_W];
  assign accept   = inv_valid && (inv_addr >= ADDR_L) && (inv_addr <= ADDR_H);

  assign cmd_valid = (state == FLUSH) || !q_empty;
  assign out_valid = {NUM_CONSUMERS{cmd_valid}} & ~done;
  assign acked     = out_ack & out_valid;
  assign retire    = cmd_valid && (&(done | acked));
  assign pop       = retire && (state == NORMAL);

  // a lone head some consumer already took must be re-sent, not coalesced
  assign dup      = accept && !q_empty && (line == q_tail) &&
                    !((state == NORMAL) && q_single && (|done));
  assign push_req = accept && !dup;
  assign overflow = push_req && q_full && !pop;
  assign push     = push_req && !overflow;

  inv_ring_buffer #(.DEPTH(DEPTH), .W(LINE_ADDR_W)) u_ring (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (overflow),
    .push   (push),
    .pop    (pop),
    .wdata  (line),
    .head   (q_head),
    .tail   (q_tail),
    .full   (q_full),
    .empty  (q_empty),
    .single (q_single)
  );

  assign out_flush_all = (state == FLUSH);
  assign out_line_addr = (state == NORMAL && !q_empty) ? q_head : '0;
  assign busy          = cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= NORMAL;
      done         <= '0;
      overflow_cnt <= '0;
    end else begin
      if (overflow)                        state <= FLUSH;
      else if (state == FLUSH && retire)   state <= NORMAL;

      if (overflow || retire) done <= '0;
      else                    done <= done | acked;

      if (overflow && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

endmodule
